// File: rtl/portao_sequenciador_pkg.sv
// Shared state codes and seven-segment glyphs
// for the garage-gate motion sequencer.
package portao_pkg;

    typedef enum logic [2:0] {
        CLOSED  = 3'd0,
        OPENING = 3'd1,
        OPEN    = 3'd2,
        CLOSING = 3'd3,
        PAUSE_O = 3'd4,
        PAUSE_C = 3'd5
    } state_t;

    localparam logic [6:0] HEX_F = 7'b0001110;
    localparam logic [6:0] HEX_A = 7'b0001000;
    localparam logic [6:0] HEX_0 = 7'b1000000;
    localparam logic [6:0] HEX_P = 7'b0001100;

    function automatic logic [6:0] glyph(state_t s);
        logic [6:0] g;
        case (s)
            OPEN:             g = HEX_A;
            OPENING, CLOSING: g = HEX_0;
            PAUSE_O, PAUSE_C: g = HEX_P;
            default:          g = HEX_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/portao_sequenciador_if.sv
// Board-side signal bundle of the gate sequencer:
// button/sensor inputs and motor/display outputs.
interface portao_sequenciador_if;
    logic       key_n;
    logic       obstacle;
    logic       motor_en;
    logic       motor_dir;
    logic       LEDG;
    logic       LEDR;
    logic [6:0] HEX0;
    logic [2:0] state;

    modport master (
        output key_n, obstacle,
        input  motor_en, motor_dir, LEDG, LEDR, HEX0, state
    );

    modport slave (
        input  key_n, obstacle,
        output motor_en, motor_dir, LEDG, LEDR, HEX0, state
    );
endinterface

// File: rtl/portao_sequenciador_debounce_key.sv
// Key synchronizer and debouncer; emits a one-cycle
// press pulse when the accepted level falls.
module debounce_key #(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic CLOCK_27,
    input  logic reset,
    input  logic key_n,
    output logic press
);
    localparam int CW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLOCK_27) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_q <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= key_n;
            sync2   <= sync1;
            level_q <= level;
            press   <= level_q & ~level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/portao_sequenciador.sv
// Gate motion sequencer: FSM, travel position,
// auto-close timer and obstacle reversal.
module portao_sequenciador
    import portao_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int TRAVEL_CYCLES   = 135000000,
    parameter int HOLD_CYCLES     = 270000000
) (
    input logic CLOCK_27,
    input logic reset,
    portao_sequenciador_if.slave io
);
    localparam int PW = $clog2(TRAVEL_CYCLES + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [PW-1:0] POS_TOP  = PW'(TRAVEL_CYCLES);
    localparam logic [PW-1:0] POS_LAST = PW'(TRAVEL_CYCLES - 1);
    localparam logic [PW-1:0] POS_ONE  = PW'(1);
    localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_CYCLES - 1);

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] pos;
    logic [PW-1:0] pos_d;
    logic [HW-1:0] hold;
    logic [HW-1:0] hold_d;
    logic          obs_s1;
    logic          obs;
    logic          press;

    debounce_key #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .CLOCK_27(CLOCK_27),
        .reset   (reset),
        .key_n   (io.key_n),
        .press   (press)
    );

    always_ff @(posedge CLOCK_27) begin
        if (reset) begin
            state_q <= CLOSED;
            pos     <= '0;
            hold    <= '0;
            obs_s1  <= 1'b0;
            obs     <= 1'b0;
        end else begin
            state_q <= state_d;
            pos     <= pos_d;
            hold    <= hold_d;
            obs_s1  <= io.obstacle;
            obs     <= obs_s1;
        end
    end

    // obstacle outranks press, press outranks the timers
    always_comb begin
        state_d = state_q;
        pos_d   = pos;
        hold_d  = hold;
        case (state_q)
            CLOSED: begin
                if (press) state_d = OPENING;
            end
            OPENING: begin
                if (press) begin
                    state_d = PAUSE_O;
                end else if (pos == POS_LAST) begin
                    state_d = OPEN;
                    pos_d   = POS_TOP;
                    hold_d  = HOLD_LD;
                end else begin
                    pos_d = pos + PW'(1);
                end
            end
            OPEN: begin
                if (obs) begin
                    hold_d = HOLD_LD;
                end else if (press || hold == '0) begin
                    state_d = CLOSING;
                end else begin
                    hold_d = hold - HW'(1);
                end
            end
            CLOSING: begin
                if (obs) begin
                    state_d = OPENING;
                end else if (press) begin
                    state_d = PAUSE_C;
                end else if (pos == POS_ONE) begin
                    state_d = CLOSED;
                    pos_d   = '0;
                end else begin
                    pos_d = pos - PW'(1);
                end
            end
            PAUSE_O: begin
                if (press) state_d = CLOSING;
            end
            PAUSE_C: begin
                if (press) state_d = OPENING;
            end
            default: begin
                state_d = CLOSED;
                pos_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    assign io.motor_en  = (state_q == OPENING) || (state_q == CLOSING);
    assign io.motor_dir = (state_q == OPENING);
    assign io.LEDG      = (state_q == OPENING);
    assign io.LEDR      = (state_q == CLOSING);
    assign io.HEX0      = glyph(state_q);
    assign io.state     = state_q;
endmodule
